// File: rtl/uart_rx_ctrl_if.sv
// Host-side read port of uart_rx_ctrl: FIFO head, valid/ready handshake and occupancy.
interface uart_rx_ctrl_if #(
    parameter int CNT_W = 3
);
    logic [7:0]       o_data;
    logic             o_data_perr;
    logic             o_valid;
    logic             i_ready;
    logic [CNT_W-1:0] o_count;

    modport master (
        output o_data,
        output o_data_perr,
        output o_valid,
        output o_count,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_data_perr,
        input  o_valid,
        input  o_count,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Post-receiver controller: drives the receiver prescale, checks each 11-bit frame,
// buffers good bytes in a small FIFO for the host and keeps sticky error status.
module uart_rx_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic [1:0]  i_prescale_sel,
    input  logic        i_par_en,
    input  logic        i_par_odd,
    input  logic        i_active_flag,
    input  logic        i_frame_done,
    input  logic [10:0] i_frame,
    input  logic        i_err_clr,
    output logic [5:0]  o_prescale,
    output logic        o_busy,
    output logic        o_par_err,
    output logic        o_frm_err,
    output logic        o_overrun,
    uart_rx_ctrl_if.master host
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, PUSH} state_t;

    state_t           state;
    logic             done_q;
    logic             done_rise;
    logic [10:0]      frame_q;
    logic             frm_bad;
    logic             par_bad;
    logic [8:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push;
    logic             space;

    function automatic logic [5:0] prescale_of(input logic [1:0] sel);
        case (sel)
            2'b01:   prescale_of = 6'd16;
            2'b10:   prescale_of = 6'd32;
            default: prescale_of = 6'd8;
        endcase
    endfunction

    assign done_rise = i_frame_done && !done_q;
    assign o_busy    = (state != IDLE) || i_active_flag;

    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    assign pop   = host.o_valid && host.i_ready;
    assign space = (count != CNT_W'(DEPTH)) || pop;
    assign push  = (state == PUSH) && space;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            frm_bad    <= 1'b0;
            par_bad    <= 1'b0;
            o_prescale <= 6'd8;
            o_par_err  <= 1'b0;
            o_frm_err  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            done_q <= i_frame_done;
            // Prescale only moves between frames so the receiver never sees a mid-frame change.
            if (state == IDLE && !i_active_flag)
                o_prescale <= prescale_of(i_prescale_sel);
            case (state)
                IDLE: begin
                    if (done_rise)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    frm_bad <= frame_q[0] | ~frame_q[10];
                    par_bad <= i_par_en & (^frame_q[9:1] ^ i_par_odd);
                    state   <= CHECK;
                end
                CHECK: begin
                    if (frm_bad) begin
                        o_frm_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        if (par_bad)
                            o_par_err <= 1'b1;
                        state <= PUSH;
                    end
                end
                PUSH: begin
                    if (!space)
                        o_overrun <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (i_err_clr) begin
                o_par_err <= 1'b0;
                o_frm_err <= 1'b0;
                o_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == IDLE && done_rise)
            frame_q <= i_frame;
        if (push)
            mem[wr_ptr] <= {par_bad, frame_q[8:1]};
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    assign host.o_valid     = (count != '0);
    assign host.o_count     = count;
    assign host.o_data      = host.o_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign host.o_data_perr = host.o_valid ? mem[rd_ptr][8]   : 1'b0;
endmodule
